// File: rtl/convolution_pkg.sv
// Shared definitions for the convolution input loader.
// Holds the default frame geometry, the word-counter width and the loader
// FSM state encoding used by the top level.
package convolution_pkg;

  localparam int CONV_DATA_W        = 32;
  localparam int CONV_IMG_DEPTH     = 64;
  localparam int CONV_IMG_ADDR_W    = 6;
  localparam int CONV_KERNEL_DEPTH  = 4;
  localparam int CONV_KERNEL_ADDR_W = 2;
  localparam int FRAME_WORDS        = CONV_KERNEL_DEPTH + CONV_IMG_DEPTH;
  localparam int CNT_W              = 7;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_START = 2'd2,
    ST_RUN   = 2'd3
  } conv_state_e;

endpackage

// File: rtl/conv_sp_ram.sv
// Simple RAM with one write port and one registered read port.
// Ports:
//   clk            clock
//   rst            synchronous active-high reset (clears the read register only)
//   we/waddr/wdata write enable, address and data
//   re/raddr       read enable and address; q updates on the edge where re=1
//   q              registered read data, holds while re=0
module conv_sp_ram #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] q_r;

  // Storage write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port with one cycle latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= {DATA_W{1'b0}};
    end else if (re) begin
      q_r <= mem_r[raddr];
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/convolution_input_loader.sv
// Stream-to-RAM loader and start/done sequencer for the convolution core.
// A frame of KERNEL_DEPTH+IMG_DEPTH words arrives on s_valid/s_ready/s_data
// (s_last on the final word). Kernel words fill the kernel RAM, the rest fill
// the image RAM, then the core is started via ap_ctrl_hs and the RAMs serve
// the core's img/kernel read ports.
// Ports:
//   ap_clk, ap_rst                    clock, synchronous active-high reset
//   s_valid, s_ready, s_data, s_last  input word stream
//   conv_start, conv_ready, conv_done core start handshake
//   img_ce0/img_address0/img_q0       core image read port
//   kernel_ce0/kernel_address0/kernel_q0 core kernel read port
//   busy                              high outside LOAD
//   frame_done, frame_err             one-cycle status pulses
module convolution_input_loader
  import convolution_pkg::*;
#(
  parameter int DATA_W        = CONV_DATA_W,
  parameter int IMG_DEPTH     = CONV_IMG_DEPTH,
  parameter int IMG_ADDR_W    = CONV_IMG_ADDR_W,
  parameter int KERNEL_DEPTH  = CONV_KERNEL_DEPTH,
  parameter int KERNEL_ADDR_W = CONV_KERNEL_ADDR_W
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_W-1:0]        s_data,
  input  logic                     s_last,
  output logic                     conv_start,
  input  logic                     conv_ready,
  input  logic                     conv_done,
  input  logic                     img_ce0,
  input  logic [IMG_ADDR_W-1:0]    img_address0,
  output logic [DATA_W-1:0]        img_q0,
  input  logic                     kernel_ce0,
  input  logic [KERNEL_ADDR_W-1:0] kernel_address0,
  output logic [DATA_W-1:0]        kernel_q0,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     frame_err
);

  localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(KERNEL_DEPTH + IMG_DEPTH - 1);
  localparam logic [CNT_W-1:0] KERNEL_IDX = CNT_W'(KERNEL_DEPTH);

  conv_state_e        state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               frame_done_r;
  logic               frame_err_r;

  logic               s_ready_s;
  logic               accept_s;
  logic               load_wr_s;
  logic               kernel_we_s;
  logic               img_we_s;

  // Ready is also held low while reset is asserted so nothing is taken
  // in the reset cycle regardless of the pre-reset state.
  assign s_ready_s   = ((state_r == ST_LOAD) || (state_r == ST_DRAIN)) && !ap_rst;
  assign accept_s    = s_valid && s_ready_s;
  assign load_wr_s   = accept_s && (state_r == ST_LOAD);
  assign kernel_we_s = load_wr_s && (cnt_r < KERNEL_IDX);
  assign img_we_s    = load_wr_s && (cnt_r >= KERNEL_IDX);

  // Loader FSM, word counter and status pulses.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_r      <= ST_LOAD;
      cnt_r        <= {CNT_W{1'b0}};
      frame_done_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      frame_err_r  <= 1'b0;
      case (state_r)
        ST_LOAD: begin
          if (accept_s) begin
            if (cnt_r == LAST_IDX) begin
              // Full word count reached: good frame only if it is marked last.
              cnt_r <= {CNT_W{1'b0}};
              if (s_last) begin
                state_r <= ST_START;
              end else begin
                frame_err_r <= 1'b1;
                state_r     <= ST_DRAIN;
              end
            end else if (s_last) begin
              frame_err_r <= 1'b1;
              cnt_r       <= {CNT_W{1'b0}};
            end else begin
              cnt_r <= cnt_r + 7'd1;
            end
          end
        end
        ST_DRAIN: begin
          if (accept_s && s_last) begin
            state_r <= ST_LOAD;
            cnt_r   <= {CNT_W{1'b0}};
          end
        end
        ST_START: begin
          if (conv_ready) begin
            if (conv_done) begin
              frame_done_r <= 1'b1;
              state_r      <= ST_LOAD;
            end else begin
              state_r <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (conv_done) begin
            frame_done_r <= 1'b1;
            cnt_r        <= {CNT_W{1'b0}};
            state_r      <= ST_LOAD;
          end
        end
        default: begin
          state_r <= ST_LOAD;
          cnt_r   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  conv_sp_ram #(
    .DEPTH  (KERNEL_DEPTH),
    .ADDR_W (KERNEL_ADDR_W),
    .DATA_W (DATA_W)
  ) u_kernel_ram (
    .clk   (ap_clk),
    .rst   (ap_rst),
    .we    (kernel_we_s),
    .waddr (KERNEL_ADDR_W'(cnt_r)),
    .wdata (s_data),
    .re    (kernel_ce0),
    .raddr (kernel_address0),
    .q     (kernel_q0)
  );

  // Image words start after the kernel words, so the image address is the
  // counter minus the kernel depth.
  conv_sp_ram #(
    .DEPTH  (IMG_DEPTH),
    .ADDR_W (IMG_ADDR_W),
    .DATA_W (DATA_W)
  ) u_img_ram (
    .clk   (ap_clk),
    .rst   (ap_rst),
    .we    (img_we_s),
    .waddr (IMG_ADDR_W'(cnt_r - KERNEL_IDX)),
    .wdata (s_data),
    .re    (img_ce0),
    .raddr (img_address0),
    .q     (img_q0)
  );

  assign s_ready    = s_ready_s;
  assign conv_start = (state_r == ST_START);
  assign busy       = (state_r != ST_LOAD);
  assign frame_done = frame_done_r;
  assign frame_err  = frame_err_r;

endmodule

// File: tb/tb_convolution_input_loader.sv
// Self-checking bench for convolution_input_loader.
module tb_convolution_input_loader;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_last;
  logic        conv_start;
  logic        conv_ready;
  logic        conv_done;
  logic        img_ce0;
  logic [5:0]  img_address0;
  logic [31:0] img_q0;
  logic        kernel_ce0;
  logic [1:0]  kernel_address0;
  logic [31:0] kernel_q0;
  logic        busy;
  logic        frame_done;
  logic        frame_err;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int start_cyc = 0;

  // Reference memory image: frame word k lands at position k while k < 68.
  logic [31:0] mk [4];
  logic [31:0] mi [64];

  typedef struct {
    bit          is_img;
    int          addr;
    logic [31:0] exp;
  } rd_vec_t;

  rd_vec_t tbl [7];

  convolution_input_loader dut (
    .ap_clk          (ap_clk),
    .ap_rst          (ap_rst),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .s_data          (s_data),
    .s_last          (s_last),
    .conv_start      (conv_start),
    .conv_ready      (conv_ready),
    .conv_done       (conv_done),
    .img_ce0         (img_ce0),
    .img_address0    (img_address0),
    .img_q0          (img_q0),
    .kernel_ce0      (kernel_ce0),
    .kernel_address0 (kernel_address0),
    .kernel_q0       (kernel_q0),
    .busy            (busy),
    .frame_done      (frame_done),
    .frame_err       (frame_err)
  );

  always #5 ap_clk = ~ap_clk;

  // Pulse/cycle counters, sampled on the active edge (pre-update values).
  always @(posedge ap_clk) begin
    if (frame_done === 1'b1) done_cnt <= done_cnt + 1;
    if (frame_err === 1'b1) err_cnt <= err_cnt + 1;
    if (conv_start === 1'b1) start_cyc <= start_cyc + 1;
  end

  task automatic tick();
    @(negedge ap_clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_write(input int idx, input logic [31:0] d);
    if (idx < 4) mk[idx] = d;
    else if (idx < 68) mi[idx-4] = d;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last);
    int budget = 50;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (s_ready !== 1'b1 && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: s_ready=%0b expected 1", s_ready);
    end
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Sends n words, s_last on the final one; rnd selects random data/gaps.
  task automatic send_frame(input int n, input logic [31:0] base, input bit rnd);
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      if (rnd) begin
        d = $urandom;
        for (int g = $urandom_range(0, 3); g > 0; g--) begin
          s_valid = 1'b0;
          tick();
        end
      end else begin
        d = base + i;
      end
      send_word(d, (i == n - 1));
      model_write(i, d);
    end
  endtask

  // Core model: entered in the first START cycle.
  task automatic finish_frame(input int rdly, input int ddly);
    int d0;
    d0 = done_cnt;
    chk("start_high", conv_start, 1);
    chk("start_busy", busy, 1);
    chk("start_no_ready", s_ready, 0);
    s_valid = 1'b1;
    s_last  = 1'b1;
    for (int i = 0; i < rdly; i++) begin
      tick();
      chk("start_hold", conv_start, 1);
      chk("start_bp", s_ready, 0);
    end
    conv_ready = 1'b1;
    tick();
    conv_ready = 1'b0;
    chk("run_start_low", conv_start, 0);
    chk("run_busy", busy, 1);
    for (int i = 0; i < ddly; i++) begin
      tick();
      chk("run_bp", s_ready, 0);
    end
    conv_done = 1'b1;
    tick();
    conv_done = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("done_pulse", frame_done, 1);
    chk("done_ready", s_ready, 1);
    chk("done_busy", busy, 0);
    tick();
    chk("done_pulse_end", frame_done, 0);
    chk("done_count", done_cnt, d0 + 1);
  endtask

  task automatic read_mem(input bit is_img, input int addr, output logic [31:0] q);
    if (is_img) begin
      img_ce0 = 1'b1;
      img_address0 = addr[5:0];
    end else begin
      kernel_ce0 = 1'b1;
      kernel_address0 = addr[1:0];
    end
    tick();
    q = is_img ? img_q0 : kernel_q0;
    img_ce0 = 1'b0;
    kernel_ce0 = 1'b0;
  endtask

  initial begin
    logic [31:0] q;
    int e0;
    int s0;

    tbl[0] = '{1'b0, 2, 32'd102};
    tbl[1] = '{1'b0, 0, 32'd100};
    tbl[2] = '{1'b0, 3, 32'd103};
    tbl[3] = '{1'b1, 63, 32'd167};
    tbl[4] = '{1'b1, 0, 32'd104};
    tbl[5] = '{1'b1, 31, 32'd135};
    tbl[6] = '{1'b1, 7, 32'd111};

    ap_rst = 1'b1;
    s_valid = 1'b0;
    s_data = 32'd0;
    s_last = 1'b0;
    conv_ready = 1'b0;
    conv_done = 1'b0;
    img_ce0 = 1'b0;
    img_address0 = 6'd0;
    kernel_ce0 = 1'b0;
    kernel_address0 = 2'd0;

    // Reset values
    tick();
    tick();
    chk("rst_s_ready", s_ready, 0);
    chk("rst_conv_start", conv_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_img_q0", img_q0, 0);
    chk("rst_kernel_q0", kernel_q0, 0);
    ap_rst = 1'b0;
    tick();
    chk("post_rst_s_ready", s_ready, 1);

    // Nominal frame; table of reads issued while the core is in RUN
    send_frame(68, 32'd100, 1'b0);
    chk("start_t1", conv_start, 1);
    conv_ready = 1'b1;
    tick();
    conv_ready = 1'b0;
    chk("nom_run", conv_start, 0);
    for (int i = 0; i < 7; i++) begin
      read_mem(tbl[i].is_img, tbl[i].addr, q);
      chk("nom_read", q, tbl[i].exp);
      img_address0 = 6'd1;
      kernel_address0 = 2'd1;
      tick();
      chk("nom_read_hold", tbl[i].is_img ? img_q0 : kernel_q0, tbl[i].exp);
    end
    chk("nom_run_busy", busy, 1);
    conv_done = 1'b1;
    tick();
    conv_done = 1'b0;
    chk("nom_done", frame_done, 1);
    chk("nom_done_ready", s_ready, 1);
    tick();
    chk("nom_done_once", done_cnt, 1);

    // Short frame
    e0 = err_cnt;
    s0 = start_cyc;
    send_frame(11, 32'd500, 1'b0);
    chk("short_err_pulse", frame_err, 1);
    chk("short_busy", busy, 0);
    tick();
    chk("short_err_count", err_cnt, e0 + 1);
    chk("short_no_start", start_cyc, s0);
    send_frame(68, 32'd200, 1'b0);
    finish_frame(0, 5);
    read_mem(1'b1, 0, q);
    chk("short_next_img0", q, 32'd204);
    read_mem(1'b0, 0, q);
    chk("short_next_k0", q, 32'd200);

    // Long frame
    e0 = err_cnt;
    s0 = start_cyc;
    for (int i = 0; i < 70; i++) begin
      send_word(32'd300 + i, (i == 69));
      model_write(i, 32'd300 + i);
      if (i == 67) begin
        chk("long_err_pulse", frame_err, 1);
        chk("long_drain_busy", busy, 1);
      end
    end
    chk("long_back_load", busy, 0);
    tick();
    chk("long_err_count", err_cnt, e0 + 1);
    chk("long_no_start", start_cyc, s0);
    read_mem(1'b0, 0, q);
    chk("long_k0_kept", q, 32'd300);
    read_mem(1'b1, 63, q);
    chk("long_img63_kept", q, 32'd367);
    send_frame(68, 32'd400, 1'b0);
    finish_frame(2, 3);
    read_mem(1'b0, 0, q);
    chk("long_next_k0", q, 32'd400);
    read_mem(1'b1, 63, q);
    chk("long_next_img63", q, 32'd467);

    // Same-cycle ready and done
    send_frame(68, 32'd600, 1'b0);
    chk("same_start", conv_start, 1);
    conv_ready = 1'b1;
    conv_done = 1'b1;
    tick();
    conv_ready = 1'b0;
    conv_done = 1'b0;
    chk("same_start_low", conv_start, 0);
    chk("same_done", frame_done, 1);
    chk("same_ready", s_ready, 1);
    tick();
    chk("same_done_end", frame_done, 0);

    // Random frames with gaps, checked against the reference memory image
    for (int f = 0; f < 3; f++) begin
      send_frame(68, 32'd0, 1'b1);
      finish_frame($urandom_range(0, 3), $urandom_range(1, 10));
      for (int r = 0; r < 8; r++) begin
        int a;
        bit im;
        im = 1'($urandom_range(0, 1));
        a = im ? $urandom_range(0, 63) : $urandom_range(0, 3);
        read_mem(im, a, q);
        chk("rand_read", q, im ? mi[a] : mk[a]);
      end
    end

    // Reset during RUN
    send_frame(68, 32'd700, 1'b0);
    conv_ready = 1'b1;
    tick();
    conv_ready = 1'b0;
    read_mem(1'b1, 5, q);
    chk("rr_pre_read", q, 32'd709);
    ap_rst = 1'b1;
    tick();
    chk("rr_conv_start", conv_start, 0);
    chk("rr_busy", busy, 0);
    chk("rr_img_q0", img_q0, 0);
    chk("rr_kernel_q0", kernel_q0, 0);
    chk("rr_s_ready_in_rst", s_ready, 0);
    ap_rst = 1'b0;
    #1;
    chk("rr_s_ready", s_ready, 1);
    conv_done = 1'b1;
    conv_ready = 1'b1;
    tick();
    conv_done = 1'b0;
    conv_ready = 1'b0;
    chk("rr_ignore_done", frame_done, 0);
    chk("rr_ignore_busy", busy, 0);
    send_frame(68, 32'd800, 1'b0);
    finish_frame(1, 2);
    read_mem(1'b0, 0, q);
    chk("rr_fresh_k0", q, 32'd800);
    read_mem(1'b1, 0, q);
    chk("rr_fresh_img0", q, 32'd804);
    read_mem(1'b1, 63, q);
    chk("rr_fresh_img63", q, 32'd867);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
